// File: rtl/flash_fetch_arbiter.sv
// Sequencer and two-way arbiter for the byte-wide flash array.
// Serves a 32-bit instruction fetcher and a byte load/store port using pipelined byte reads.
module flash_fetch_arbiter #(
  parameter int unsigned       PC_W      = 16,
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_wdata,
  output logic              d_done,
  output logic [7:0]        d_rdata,
  output logic              busy,
  output logic              flash_we,
  output logic              flash_re,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [7:0]        flash_in,
  input  logic [7:0]        flash_out
);

  typedef enum logic [1:0] {StIdle, StFetch, StDread, StDwrite} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_fetch_q, last_fetch_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        in_q, in_d;
  logic [23:0]       buf_q, buf_d;
  logic [31:0]       instr_q, instr_d;
  logic              fvalid_q, fvalid_d;
  logic              done_q, done_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              grant_fetch, grant_data;

  // On contention the side that did not win the last contest gets the grant.
  assign grant_fetch = fetch_req & (~d_req | ~last_fetch_q);
  assign grant_data  = d_req & (~fetch_req | last_fetch_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_fetch_d = last_fetch_q;
    re_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    in_d         = in_q;
    buf_d        = buf_q;
    instr_d      = instr_q;
    fvalid_d     = 1'b0;
    done_d       = 1'b0;
    rdata_d      = rdata_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fetch_req && d_req) begin
          last_fetch_d = grant_fetch;
        end
        if (grant_fetch) begin
          state_d = StFetch;
          re_d    = 1'b1;
          addr_d  = BASE_ADDR + ADDR_W'(fetch_addr);
        end else if (grant_data) begin
          addr_d = d_addr;
          if (d_we) begin
            state_d = StDwrite;
            we_d    = 1'b1;
            in_d    = d_wdata;
          end else begin
            state_d = StDread;
            re_d    = 1'b1;
          end
        end
      end

      StFetch: begin
        if (fetch_flush) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < 3'd3) begin
            re_d   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end
          // Bytes return one cycle behind their address; the word is only
          // published once the last byte lands so a flush leaves it untouched.
          case (cnt_q)
            3'd1: buf_d[7:0]   = flash_out;
            3'd2: buf_d[15:8]  = flash_out;
            3'd3: buf_d[23:16] = flash_out;
            3'd4: begin
              instr_d  = {flash_out, buf_q};
              fvalid_d = 1'b1;
              state_d  = StIdle;
            end
            default: ;
          endcase
        end
      end

      StDread: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = flash_out;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      StDwrite: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_fetch_q <= 1'b0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      in_q         <= '0;
      buf_q        <= '0;
      instr_q      <= '0;
      fvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_fetch_q <= last_fetch_d;
      re_q         <= re_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      in_q         <= in_d;
      buf_q        <= buf_d;
      instr_q      <= instr_d;
      fvalid_q     <= fvalid_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
    end
  end

  assign fetch_valid = fvalid_q;
  assign fetch_instr = instr_q;
  assign d_done      = done_q;
  assign d_rdata     = rdata_q;
  assign busy        = (state_q != StIdle);
  assign flash_we    = we_q;
  assign flash_re    = re_q;
  assign flash_addr  = addr_q;
  assign flash_in    = in_q;

endmodule
